// File: rtl/gate_sequencer.sv
// gate_sequencer: run controller for the gate array.
// Drives the shared sync / transmit-start / receive-pull / gate-clock strobes
// for GATE_NUMBER gates. Each run captures a gate mask, a pulse count
// (0 = continuous) and a ready-wait timeout (0 = none), then alternates
// WAIT (until every participating gate is ready) and PULSE. A run ends in DONE,
// in ERR (timeout, failing gates reported) or by abort.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start, i_abort    run request (IDLE only) / terminate run
//   i_gate_mask         participating gates, sampled at accepted start
//   i_cycles            pulses per run, 0 = continuous, sampled at start
//   i_timeout           max WAIT cycles without ready, 0 = none, sampled at start
//   i_tx_ready/i_rx_ready  per-gate ready inputs
//   o_gen_sync, o_tx_start, o_rx_pull, o_clock  registered state decodes
//   o_busy, o_done, o_timeout_err               status
//   o_fail_mask         masked gates not ready at timeout
//   o_cycle_cnt         pulses issued in the current or last run
module gate_sequencer #(
    parameter int unsigned GATE_NUMBER = 4,
    parameter int unsigned CYCLE_W     = 8,
    parameter int unsigned TIMEOUT_W   = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [GATE_NUMBER-1:0] i_gate_mask,
    input  logic [CYCLE_W-1:0]     i_cycles,
    input  logic [TIMEOUT_W-1:0]   i_timeout,
    input  logic [GATE_NUMBER-1:0] i_tx_ready,
    input  logic [GATE_NUMBER-1:0] i_rx_ready,
    output logic                   o_gen_sync,
    output logic                   o_tx_start,
    output logic                   o_rx_pull,
    output logic                   o_clock,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout_err,
    output logic [GATE_NUMBER-1:0] o_fail_mask,
    output logic [CYCLE_W-1:0]     o_cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_PULSE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [GATE_NUMBER-1:0] mask_q;
    logic [CYCLE_W-1:0]     cycles_q;
    logic [TIMEOUT_W-1:0]   timeout_q;
    logic [TIMEOUT_W-1:0]   wait_cnt_q;
    logic [CYCLE_W-1:0]     cycle_cnt_q;
    logic [GATE_NUMBER-1:0] fail_mask_q;

    logic gen_sync_q, tx_start_q, rx_pull_q, clock_q, busy_q, done_q, timeout_err_q;

    logic [GATE_NUMBER-1:0] gate_ok;
    logic                   all_ready;
    logic                   start_accept;
    logic                   timeout_hit;
    logic [CYCLE_W-1:0]     cycle_inc;

    // Non-participating gates always count as ready.
    assign gate_ok      = (i_tx_ready & i_rx_ready) | ~mask_q;
    assign all_ready    = &gate_ok;
    assign start_accept = (state_q == S_IDLE) && i_start && (|i_gate_mask);
    assign timeout_hit  = (timeout_q != '0) && (wait_cnt_q == (timeout_q - TIMEOUT_W'(1)));
    assign cycle_inc    = cycle_cnt_q + CYCLE_W'(1);

    // Next-state decode; abort overrides every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_accept) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (all_ready)        state_d = S_PULSE;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_PULSE: begin
                if ((cycles_q != '0) && (cycle_inc == cycles_q)) state_d = S_DONE;
                else                                             state_d = S_WAIT;
            end
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (i_abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // State, run parameters, counters and registered strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            cycles_q      <= '0;
            timeout_q     <= '0;
            wait_cnt_q    <= '0;
            cycle_cnt_q   <= '0;
            fail_mask_q   <= '0;
            gen_sync_q    <= 1'b1;
            tx_start_q    <= 1'b0;
            rx_pull_q     <= 1'b0;
            clock_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_accept) begin
                mask_q      <= i_gate_mask;
                cycles_q    <= i_cycles;
                timeout_q   <= i_timeout;
                fail_mask_q <= '0;
            end

            // Pulse counter: cleared on start, bumped on every edge leaving PULSE.
            if (start_accept)              cycle_cnt_q <= '0;
            else if (state_q == S_PULSE)   cycle_cnt_q <= cycle_inc;

            // Wait counter is zero on the first cycle of every WAIT visit.
            if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + TIMEOUT_W'(1);
            else                   wait_cnt_q <= '0;

            if ((state_q == S_WAIT) && (state_d == S_ERR))
                fail_mask_q <= mask_q & ~(i_tx_ready & i_rx_ready);

            // Strobes are decodes of the next state so they line up with state_q.
            gen_sync_q    <= (state_d == S_IDLE);
            tx_start_q    <= (state_d == S_LAUNCH) || (state_d == S_PULSE);
            rx_pull_q     <= (state_d == S_PULSE);
            clock_q       <= (state_d == S_PULSE);
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_DONE);
            timeout_err_q <= (state_d == S_ERR);
        end
    end

    assign o_gen_sync    = gen_sync_q;
    assign o_tx_start    = tx_start_q;
    assign o_rx_pull     = rx_pull_q;
    assign o_clock       = clock_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_timeout_err = timeout_err_q;
    assign o_fail_mask   = fail_mask_q;
    assign o_cycle_cnt   = cycle_cnt_q;

endmodule
